ldpc_3gpp_dec_obuf_ctrl: RTL and testbench

Bank scheduler for the LDPC 3GPP decoder output memory. It sits between the decoder engine and the output sink, which reads one bank at a time. The block hands free banks to the engine and queues filled banks, with their tag, decfail flag and error count, for the sink. It releases a bank when the sink reports it empty, so engine writes and sink reads overlap without stalling.

---
 rtl/ldpc_3gpp_dec_obuf_ctrl.sv | 92 +++++++++
 tb/tb_ldpc_3gpp_dec_obuf_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_3gpp_dec_obuf_ctrl.sv
// rtl/ldpc_3gpp_dec_obuf_ctrl.sv - output memory bank scheduler for the LDPC decoder
// Hands free banks to the engine and queues filled banks (with tag/decfail/err) for the sink.
module ldpc_3gpp_dec_obuf_ctrl #(
    parameter int pBANK_W = 1,
    parameter int pERR_W  = 16,
    parameter int pTAG_W  = 4
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                iclkena,
    input  logic                iflush,
    input  logic                iwdone,
    input  logic [pTAG_W-1:0]   iwtag,
    input  logic                iwdecfail,
    input  logic [pERR_W-1:0]   iwerr,
    output logic [pBANK_W-1:0]  owbank,
    output logic                owfull,
    output logic                orfull,
    output logic [pBANK_W-1:0]  orbank,
    output logic [pTAG_W-1:0]   ortag,
    output logic                ordecfail,
    output logic [pERR_W-1:0]   orerr,
    input  logic                irempty,
    output logic [pBANK_W:0]    ousedw
);

    localparam int              cBANKS = 2**pBANK_W;
    localparam logic [pBANK_W:0] cMAX  = (pBANK_W+1)'(cBANKS);

    logic [pBANK_W-1:0] wptr;
    logic [pBANK_W-1:0] rptr;
    logic [pBANK_W:0]   used;

    logic [pTAG_W-1:0]  ctx_tag     [cBANKS];
    logic               ctx_decfail [cBANKS];
    logic [pERR_W-1:0]  ctx_err     [cBANKS];

    logic full;
    logic nempty;
    logic wr_acc;
    logic rd_acc;

    // Acceptance uses the pre-edge occupancy, so a release never admits a same-edge commit.
    assign full   = (used == cMAX);
    assign nempty = (used != '0);
    assign wr_acc = iwdone & ~full;
    assign rd_acc = irempty & nempty;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            wptr <= '0;
            rptr <= '0;
            used <= '0;
            for (int i = 0; i < cBANKS; i++) begin
                ctx_tag[i]     <= '0;
                ctx_decfail[i] <= 1'b0;
                ctx_err[i]     <= '0;
            end
        end else if (iclkena) begin
            if (iflush) begin
                wptr <= '0;
                rptr <= '0;
                used <= '0;
            end else begin
                if (wr_acc) begin
                    ctx_tag[wptr]     <= iwtag;
                    ctx_decfail[wptr] <= iwdecfail;
                    ctx_err[wptr]     <= iwerr;
                    wptr              <= wptr + 1'b1;
                end
                if (rd_acc) begin
                    rptr <= rptr + 1'b1;
                end
                if (wr_acc && !rd_acc) begin
                    used <= used + 1'b1;
                end else if (rd_acc && !wr_acc) begin
                    used <= used - 1'b1;
                end
            end
        end
    end

    assign owbank    = wptr;
    assign orbank    = rptr;
    assign owfull    = full;
    assign orfull    = nempty;
    assign ousedw    = used;
    assign ortag     = ctx_tag[rptr];
    assign ordecfail = ctx_decfail[rptr];
    assign orerr     = ctx_err[rptr];

endmodule

// File: tb/tb_ldpc_3gpp_dec_obuf_ctrl.sv
// tb/tb_ldpc_3gpp_dec_obuf_ctrl.sv - self-checking bench for ldpc_3gpp_dec_obuf_ctrl
// Two instances (2 and 4 banks) share stimulus; a queue model tracks each one.
module tb_ldpc_3gpp_dec_obuf_ctrl;

    logic        iclk = 1'b0;
    logic        ireset;
    logic        iclkena;
    logic        iflush;
    logic        iwdone;
    logic [3:0]  iwtag;
    logic        iwdecfail;
    logic [15:0] iwerr;
    logic        irempty;

    logic [0:0]  owbank_a, orbank_a;
    logic        owfull_a, orfull_a, ordecfail_a;
    logic [3:0]  ortag_a;
    logic [15:0] orerr_a;
    logic [1:0]  ousedw_a;

    logic [1:0]  owbank_b, orbank_b;
    logic        owfull_b, orfull_b, ordecfail_b;
    logic [3:0]  ortag_b;
    logic [15:0] orerr_b;
    logic [2:0]  ousedw_b;

    always #5 iclk = ~iclk;

    ldpc_3gpp_dec_obuf_ctrl #(.pBANK_W(1), .pERR_W(16), .pTAG_W(4)) dut_a (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iflush(iflush),
        .iwdone(iwdone), .iwtag(iwtag), .iwdecfail(iwdecfail), .iwerr(iwerr),
        .owbank(owbank_a), .owfull(owfull_a), .orfull(orfull_a), .orbank(orbank_a),
        .ortag(ortag_a), .ordecfail(ordecfail_a), .orerr(orerr_a),
        .irempty(irempty), .ousedw(ousedw_a)
    );

    ldpc_3gpp_dec_obuf_ctrl #(.pBANK_W(2), .pERR_W(16), .pTAG_W(4)) dut_b (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iflush(iflush),
        .iwdone(iwdone), .iwtag(iwtag), .iwdecfail(iwdecfail), .iwerr(iwerr),
        .owbank(owbank_b), .owfull(owfull_b), .orfull(orfull_b), .orbank(orbank_b),
        .ortag(ortag_b), .ordecfail(ordecfail_b), .orerr(orerr_b),
        .irempty(irempty), .ousedw(ousedw_b)
    );

    typedef struct packed {
        logic [3:0]  tag;
        logic        dec;
        logic [15:0] err;
    } ctx_t;

    typedef struct {
        int en, fl, wd, tag, dec, err, re;
        int wb, rb, wf, rf, used, etag, edec, eerr;
    } vec_t;

    ctx_t qa[$];
    ctx_t qb[$];
    int   nwa, nra, nwb, nrb;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vt[15];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bank queue semantics: accept decisions use occupancy before the edge.
    task automatic model_step();
        ctx_t e;
        bit   ca, ra, cb, rb;
        e = {iwtag, iwdecfail, iwerr};
        if (ireset || (iclkena && iflush)) begin
            qa.delete(); qb.delete();
            nwa = 0; nra = 0; nwb = 0; nrb = 0;
        end else if (iclkena) begin
            ra = irempty && (qa.size() != 0);
            ca = iwdone && (qa.size() != 2);
            rb = irempty && (qb.size() != 0);
            cb = iwdone && (qb.size() != 4);
            if (ra) begin void'(qa.pop_front()); nra++; end
            if (ca) begin qa.push_back(e); nwa++; end
            if (rb) begin void'(qb.pop_front()); nrb++; end
            if (cb) begin qb.push_back(e); nwb++; end
        end
    endtask

    task automatic check_model();
        chk("a.owbank", int'(owbank_a), nwa % 2);
        chk("a.orbank", int'(orbank_a), nra % 2);
        chk("a.ousedw", int'(ousedw_a), qa.size());
        chk("a.owfull", int'(owfull_a), int'(qa.size() == 2));
        chk("a.orfull", int'(orfull_a), int'(qa.size() != 0));
        if (qa.size() != 0) begin
            chk("a.ortag", int'(ortag_a), int'(qa[0].tag));
            chk("a.ordecfail", int'(ordecfail_a), int'(qa[0].dec));
            chk("a.orerr", int'(orerr_a), int'(qa[0].err));
        end
        chk("b.owbank", int'(owbank_b), nwb % 4);
        chk("b.orbank", int'(orbank_b), nrb % 4);
        chk("b.ousedw", int'(ousedw_b), qb.size());
        chk("b.owfull", int'(owfull_b), int'(qb.size() == 4));
        chk("b.orfull", int'(orfull_b), int'(qb.size() != 0));
        if (qb.size() != 0) begin
            chk("b.ortag", int'(ortag_b), int'(qb[0].tag));
            chk("b.ordecfail", int'(ordecfail_b), int'(qb[0].dec));
            chk("b.orerr", int'(orerr_b), int'(qb[0].err));
        end
    endtask

    task automatic cyc(input int en, input int fl, input int wd, input int tag,
                       input int dec, input int err, input int re);
        iclkena   = en[0];
        iflush    = fl[0];
        iwdone    = wd[0];
        iwtag     = 4'(tag);
        iwdecfail = dec[0];
        iwerr     = 16'(err);
        irempty   = re[0];
        @(posedge iclk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        ireset = 1'b1; iclkena = 1'b0; iflush = 1'b0; iwdone = 1'b0;
        iwtag = '0; iwdecfail = 1'b0; iwerr = '0; irempty = 1'b0;
        nwa = 0; nra = 0; nwb = 0; nrb = 0;
        repeat (2) begin
            @(posedge iclk);
            model_step();
        end
        #1;
        ireset = 1'b0;
        chk("rst.owbank_a", int'(owbank_a), 0);
        chk("rst.orbank_a", int'(orbank_a), 0);
        chk("rst.owfull_a", int'(owfull_a), 0);
        chk("rst.orfull_a", int'(orfull_a), 0);
        chk("rst.ousedw_a", int'(ousedw_a), 0);
        chk("rst.ortag_a", int'(ortag_a), 0);
        chk("rst.orerr_b", int'(orerr_b), 0);
        chk("rst.ousedw_b", int'(ousedw_b), 0);

        //          en fl wd tag dec err re | wb rb wf rf used etag edec eerr  (2-bank instance)
        vt[0]  = '{1, 0, 1,  3, 0, 17, 0,  1, 0, 0, 1, 1,  3, 0, 17};
        vt[1]  = '{1, 0, 0,  0, 0,  0, 1,  1, 1, 0, 0, 0,  0, 0,  0};
        vt[2]  = '{1, 0, 1,  1, 0,  5, 0,  0, 1, 0, 1, 1,  1, 0,  5};
        vt[3]  = '{1, 0, 1,  2, 1,  6, 0,  1, 1, 1, 1, 2,  1, 0,  5};
        vt[4]  = '{1, 0, 1,  9, 0, 99, 0,  1, 1, 1, 1, 2,  1, 0,  5};
        vt[5]  = '{1, 0, 0,  0, 0,  0, 1,  1, 0, 0, 1, 1,  2, 1,  6};
        vt[6]  = '{1, 0, 0,  0, 0,  0, 1,  1, 1, 0, 0, 0,  0, 0,  0};
        vt[7]  = '{1, 0, 0,  0, 0,  0, 1,  1, 1, 0, 0, 0,  0, 0,  0};
        vt[8]  = '{1, 0, 1,  4, 0,  7, 0,  0, 1, 0, 1, 1,  4, 0,  7};
        vt[9]  = '{1, 0, 1,  5, 1,  8, 0,  1, 1, 1, 1, 2,  4, 0,  7};
        vt[10] = '{1, 0, 1,  6, 0, 20, 1,  1, 0, 0, 1, 1,  5, 1,  8};
        vt[11] = '{1, 0, 1,  7, 0,  9, 1,  0, 1, 0, 1, 1,  7, 0,  9};
        vt[12] = '{0, 0, 1, 12, 1, 30, 1,  0, 1, 0, 1, 1,  7, 0,  9};
        vt[13] = '{1, 0, 1, 10, 0, 11, 0,  1, 1, 1, 1, 2,  7, 0,  9};
        vt[14] = '{1, 1, 1,  8, 0,  1, 1,  0, 0, 0, 0, 0,  0, 0,  0};

        for (int i = 0; i < 15; i++) begin
            cyc(vt[i].en, vt[i].fl, vt[i].wd, vt[i].tag, vt[i].dec, vt[i].err, vt[i].re);
            chk($sformatf("vec%0d.owbank", i), int'(owbank_a), vt[i].wb);
            chk($sformatf("vec%0d.orbank", i), int'(orbank_a), vt[i].rb);
            chk($sformatf("vec%0d.owfull", i), int'(owfull_a), vt[i].wf);
            chk($sformatf("vec%0d.orfull", i), int'(orfull_a), vt[i].rf);
            chk($sformatf("vec%0d.ousedw", i), int'(ousedw_a), vt[i].used);
            if (vt[i].rf != 0) begin
                chk($sformatf("vec%0d.ortag", i), int'(ortag_a), vt[i].etag);
                chk($sformatf("vec%0d.ordecfail", i), int'(ordecfail_a), vt[i].edec);
                chk($sformatf("vec%0d.orerr", i), int'(orerr_a), vt[i].eerr);
            end
        end

        // Wrap-around on the 4-bank instance: tags emerge in order, pointers wrap 3->0.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 1, i, i % 2, i * 3, 0);
            chk($sformatf("wrap%0d.ortag", i), int'(ortag_b), i);
            chk($sformatf("wrap%0d.orerr", i), int'(orerr_b), i * 3);
            chk($sformatf("wrap%0d.orbank", i), int'(orbank_b), i % 4);
            chk($sformatf("wrap%0d.owbank", i), int'(owbank_b), (i + 1) % 4);
            cyc(1, 0, 0, 0, 0, 0, 1);
            chk($sformatf("wrap%0d.orbank_rel", i), int'(orbank_b), (i + 1) % 4);
            chk($sformatf("wrap%0d.orfull_rel", i), int'(orfull_b), 0);
        end

        for (int i = 0; i < 800; i++) begin
            cyc(int'($urandom_range(7, 0) != 0), int'($urandom_range(39, 0) == 0),
                int'($urandom_range(1, 0)), int'($urandom_range(15, 0)),
                int'($urandom_range(1, 0)), int'($urandom_range(65535, 0)),
                int'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
